instr_encoder: RTL

Program loader for the RISC-V core's instruction memory: the encode-side counterpart of the opcode decoder in the main control path. It accepts field-level instruction requests over a valid/ready handshake and packs each one into a 32-bit RV32I word. The supported set is R_TYPE, I_TYPE, LW, SW and BEQ, matching the opcodes the controller decodes. Each word is written to consecutive instruction-memory addresses through a registered write port, so benches and boot logic can load programs without hand-assembled hex.

---
 rtl/instr_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Field-level RV32I instruction encoder that streams packed words into
// consecutive instruction-memory slots through a registered write port.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned   CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    localparam logic [2:0] K_R  = 3'd0;
    localparam logic [2:0] K_I  = 3'd1;
    localparam logic [2:0] K_LW = 3'd2;
    localparam logic [2:0] K_SW = 3'd3;
    localparam logic [2:0] K_BR = 3'd4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             legal;
    logic [CNT_W-1:0] count_inc;
    logic [31:0]      enc_word;

    assign in_ready  = (state == S_LOAD) && (count != DEPTH) && !start;
    assign accept    = in_valid && in_ready;
    assign legal     = (in_kind <= K_BR);
    assign count_inc = count + CNT_W'(1);
    assign busy      = (state == S_LOAD);
    assign done      = (state == S_DONE);

    // Field packing; fields a kind does not use never reach the word
    always_comb begin
        enc_word = '0;
        case (in_kind)
            K_R:  enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1,
                              in_funct3, in_rd, OP_R};
            K_I:  enc_word = {in_imm, in_rs1, in_funct3, in_rd, OP_I};
            K_LW: enc_word = {in_imm, in_rs1, 3'b010, in_rd, OP_LW};
            K_SW: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                              in_imm[4:0], OP_SW};
            // in_imm holds the byte offset [12:1], so imm[11] is offset[12]
            K_BR: enc_word = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, 3'b000,
                              in_imm[3:0], in_imm[10], OP_BR};
            default: enc_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state; start outranks finish and the last-slot fill
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (start)
                    state_nxt = S_LOAD;
                else if (finish || (accept && legal && (count_inc == DEPTH)))
                    state_nxt = S_DONE;
            end
            S_DONE: if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write port, word counter and sticky illegal-kind flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
                    mem_wdata <= enc_word;
                    count     <= count_inc;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
